// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the FIFO-draining UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; ser_bit is the bit the line carries after the next edge.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= data;
            r_cnt   <= '0;
        end else if (shift_en) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= ser_done ? '0 : r_cnt + 1'b1;
        end
    end

    // The output is registered downstream, so while shifting we hand over the bit that is about to become current.
    assign ser_bit  = shift_en ? r_shift[1] : r_shift[0];
    assign ser_done = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter pulling bytes from the TX FIFO read side; one CLK cycle per bit.
module uart_tx_fifo_drain
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_r_inc,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    state_t r_state;
    logic   r_tx;
    logic   r_busy;
    logic   r_par_en;
    logic   r_par_bit;

    state_t w_state_nxt;
    logic   w_tx_nxt;
    logic   w_busy_nxt;
    logic   w_load;
    logic   w_shift_en;
    logic   w_ser_bit;
    logic   w_ser_done;

    // Gated by RST so a held reset never consumes a FIFO entry.
    assign w_load     = !RST && !fifo_empty && (r_state == IDLE || r_state == STOP);
    assign w_shift_en = (r_state == DATA);

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (w_load),
        .shift_en (w_shift_en),
        .data     (fifo_rd_data),
        .ser_bit  (w_ser_bit),
        .ser_done (w_ser_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = IDLE_BIT;
        w_busy_nxt  = 1'b0;
        unique case (r_state)
            IDLE, STOP: begin
                if (w_load) begin
                    w_state_nxt = START;
                    w_tx_nxt    = START_BIT;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_state_nxt = DATA;
                w_tx_nxt    = w_ser_bit;
                w_busy_nxt  = 1'b1;
            end
            DATA: begin
                w_busy_nxt = 1'b1;
                if (!w_ser_done) begin
                    w_tx_nxt = w_ser_bit;
                end else if (r_par_en) begin
                    w_state_nxt = PARITY;
                    w_tx_nxt    = r_par_bit;
                end else begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = STOP_BIT;
                end
            end
            PARITY: begin
                w_state_nxt = STOP;
                w_tx_nxt    = STOP_BIT;
                w_busy_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_tx      <= IDLE_BIT;
            r_busy    <= 1'b0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            // Frame config is frozen at load so mid-frame changes cannot corrupt the frame.
            if (w_load) begin
                r_par_en  <= par_en;
                r_par_bit <= (par_typ == PAR_ODD) ? ~(^fifo_rd_data) : (^fifo_rd_data);
            end
        end
    end

    assign fifo_r_inc = w_load;
    assign tx_out     = r_tx;
    assign busy       = r_busy;

endmodule
